csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
- Initiator side of the CSR file port: executes Zicsr instructions (CSRRW/RS/RC and immediate forms) as read-modify-write sequences against the CSR file.
- Sits between the execute stage (valid/ready request/response) and the CSR file.
- Returns the old CSR value for writeback to rd, plus an illegal-access flag.

Parameters:
- XLEN, 32, data width of CSR values and rs1 operand.
- CSR_ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  execute stage presents a CSR instruction
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_funct3  in  3  instruction funct3
- req_addr  in  CSR_ADDR_W  target CSR address
- req_rs1_data  in  XLEN  rs1 register value
- req_zimm  in  5  immediate from the rs1 field
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_rdata  out  XLEN  old CSR value (rd writeback data)
- resp_illegal  out  1  access illegal; rd must not be written
- csr_addr  out  CSR_ADDR_W  address to CSR file
- csr_rdata  in  XLEN  combinational read data from CSR file
- csr_wdata  out  XLEN  write data to CSR file
- csr_w_enable  out  1  CSR file write strobe
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low, on rst_n; clock is clk.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0, csr_addr=0, csr_wdata=0, csr_w_enable=0, busy=0.
- FSM states: IDLE -> READ -> WRITE -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture funct3, addr and the source operand, then go to READ.
  - Source operand: req_rs1_data when funct3[2]=0; req_zimm zero-extended to XLEN when funct3[2]=1.
- READ (1 cycle):
  - csr_addr = captured addr.
  - Register csr_rdata as old value.
  - Compute new value:
    - RW (001/101): src
    - RS (010/110): old | src
    - RC (011/111): old & ~src
  - Write suppression: write_req=0 when op is RS/RC and src==0; RW always writes.
  - Illegal conditions: funct3 ∈ {000, 100}, plus the check under the optional feature.
- WRITE (1 cycle):
  - csr_w_enable = write_req & ~illegal.
  - csr_wdata = new value; csr_addr held.
  - Strobe is high for exactly one cycle at most.
- RESP:
  - resp_valid=1; resp_rdata=old (0 when illegal); resp_illegal as computed.
  - resp_rdata and resp_illegal are held stable until resp_ready=1.
  - Handshake cycle returns to IDLE.
- Latency: request accepted in cycle 0; resp_valid is high from cycle 3; minimum initiation interval 4 cycles.
- req_valid is ignored whenever state!=IDLE (req_ready=0).
- csr_w_enable=0 in every state except WRITE.
- Read-after-write of the same CSR by the next request observes the new value, because the CSR file updates on the WRITE edge.
- Reset asserted mid-operation: state goes to IDLE immediately, any pending write is dropped, and no response is issued.

Optional Feature:
- Macro CSR_ACCESS_RO_CHECK_EN.
- When defined:
  - A write attempt (write_req=1) to an address with addr[11:10]==2'b11 (read-only CSR space) sets resp_illegal=1.
  - csr_w_enable stays 0.
  - resp_rdata=0.
  - Reads of read-only CSRs with write_req=0 remain legal.
- When undefined: no read-only check; such writes are performed and resp_illegal reflects only the funct3 check.

Test Plan:
- CSRRW (001), addr 0x305, rs1=0x8000_0100, CSR old 0x0 -> csr_w_enable one cycle with wdata 0x8000_0100; resp_rdata=0x0 at cycle 3; a subsequent read returns 0x8000_0100.
- CSRRS (010), addr 0x300, rs1=0x0000_000F, old 0x0000_00F0 -> wdata 0x0000_00FF; resp_rdata=0x0000_00F0.
- CSRRC (011) with rs1=0 on 0x341 holding 0x1234 -> no csr_w_enable pulse; resp_rdata=0x1234. CSRRCI (111) zimm=0x3 on old 0xFF -> wdata 0xFC.
- Write-suppression case: CSRRS on addr 0xC00 with rs1=0 -> legal read, resp_illegal=0, no write, in both builds.
- Read-only write: CSRRW on addr 0xC00 -> with CSR_ACCESS_RO_CHECK_EN: resp_illegal=1, no write; without it: write performed, resp_illegal=0. funct3=100 -> resp_illegal=1, no write, in both builds.
- resp_ready held low 3 cycles -> resp_valid and resp_rdata stable, req_ready=0, a second req_valid is ignored.
- rst_n pulsed low during WRITE -> csr_w_enable drops asynchronously, state=IDLE, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/csr_access_unit_if.sv
// Request/response and CSR-file port bundle for csr_access_unit.
// The unit connects through the slave modport. The master modport is the view
// of its surroundings, which are the execute stage and the CSR file.
// Signals:
//   req_*   execute-stage request (valid/ready), funct3, address, rs1 data, zimm
//   resp_*  result handshake, old CSR value, illegal flag
//   csr_*   CSR file port: address, combinational read data, write data, strobe
//   busy    unit is not idle
interface csr_access_unit_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned CSR_ADDR_W = 12
);
   localparam int unsigned ZIMM_W = 5;

   logic                  req_valid;
   logic                  req_ready;
   logic [2:0]            req_funct3;
   logic [CSR_ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]       req_rs1_data;
   logic [ZIMM_W-1:0]     req_zimm;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [XLEN-1:0]       resp_rdata;
   logic                  resp_illegal;

   logic [CSR_ADDR_W-1:0] csr_addr;
   logic [XLEN-1:0]       csr_rdata;
   logic [XLEN-1:0]       csr_wdata;
   logic                  csr_w_enable;

   logic                  busy;

   modport slave (
      input  req_valid, req_funct3, req_addr, req_rs1_data, req_zimm,
      input  resp_ready, csr_rdata,
      output req_ready, resp_valid, resp_rdata, resp_illegal,
      output csr_addr, csr_wdata, csr_w_enable, busy
   );

   modport master (
      output req_valid, req_funct3, req_addr, req_rs1_data, req_zimm,
      output resp_ready, csr_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_illegal,
      input  csr_addr, csr_wdata, csr_w_enable, busy
   );
endinterface

// File: rtl/csr_access_unit.sv
// csr_access_unit: executes Zicsr instructions (CSRRW/RS/RC and their
// immediate forms) as read-modify-write sequences against the CSR file.
// The FSM runs IDLE -> READ -> WRITE -> RESP. It returns the old CSR value and
// an illegal-access flag.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         csr_access_unit_if.slave (request, response and CSR-file port)
// Optional feature, macro CSR_ACCESS_RO_CHECK_EN: a write attempt to the
// read-only CSR space (addr[11:10] == 2'b11) is flagged illegal and suppressed.
module csr_access_unit #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned CSR_ADDR_W = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   csr_access_unit_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [XLEN-1:0]       src_q, src_d;
   logic [XLEN-1:0]       old_q, old_d;
   logic                  illegal_q, illegal_d;

   logic                  req_ready_q, req_ready_d;
   logic                  busy_q, busy_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
   logic                  resp_illegal_q, resp_illegal_d;
   logic [CSR_ADDR_W-1:0] csr_addr_q, csr_addr_d;
   logic [XLEN-1:0]       csr_wdata_q, csr_wdata_d;
   logic                  csr_w_enable_q, csr_w_enable_d;

   logic [XLEN-1:0]       new_val;
   logic                  write_req;
   logic                  illegal;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         funct3_q       <= 3'b000;
         src_q          <= '0;
         old_q          <= '0;
         illegal_q      <= 1'b0;
         req_ready_q    <= 1'b1;
         busy_q         <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= '0;
         resp_illegal_q <= 1'b0;
         csr_addr_q     <= '0;
         csr_wdata_q    <= '0;
         csr_w_enable_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         funct3_q       <= funct3_d;
         src_q          <= src_d;
         old_q          <= old_d;
         illegal_q      <= illegal_d;
         req_ready_q    <= req_ready_d;
         busy_q         <= busy_d;
         resp_valid_q   <= resp_valid_d;
         resp_rdata_q   <= resp_rdata_d;
         resp_illegal_q <= resp_illegal_d;
         csr_addr_q     <= csr_addr_d;
         csr_wdata_q    <= csr_wdata_d;
         csr_w_enable_q <= csr_w_enable_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      funct3_d       = funct3_q;
      src_d          = src_q;
      old_d          = old_q;
      illegal_d      = illegal_q;
      resp_valid_d   = resp_valid_q;
      resp_rdata_d   = resp_rdata_q;
      resp_illegal_d = resp_illegal_q;
      csr_addr_d     = csr_addr_q;
      csr_wdata_d    = csr_wdata_q;
      csr_w_enable_d = 1'b0;
      new_val        = '0;
      write_req      = 1'b0;
      illegal        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               funct3_d   = bus.req_funct3;
               csr_addr_d = bus.req_addr;
               src_d      = bus.req_funct3[2] ? XLEN'(bus.req_zimm) : bus.req_rs1_data;
               state_d    = READ;
            end
         end
         READ: begin
            // The CSR file answers combinationally on the address registered at accept.
            old_d = bus.csr_rdata;
            unique case (funct3_q[1:0])
               2'b01:   new_val = src_q;
               2'b10:   new_val = bus.csr_rdata | src_q;
               2'b11:   new_val = bus.csr_rdata & ~src_q;
               default: new_val = '0;
            endcase
            // A set or clear with a zero mask is a pure read.
            write_req = (funct3_q[1:0] == 2'b01) || (src_q != '0);
            illegal   = (funct3_q[1:0] == 2'b00);
`ifdef CSR_ACCESS_RO_CHECK_EN
            if (write_req && (csr_addr_q[CSR_ADDR_W-1 -: 2] == 2'b11)) begin
               illegal = 1'b1;
            end
`endif
            illegal_d      = illegal;
            csr_w_enable_d = write_req & ~illegal;
            csr_wdata_d    = new_val;
            state_d        = WRITE;
         end
         WRITE: begin
            resp_valid_d   = 1'b1;
            resp_rdata_d   = illegal_q ? '0 : old_q;
            resp_illegal_d = illegal_q;
            state_d        = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.busy         = busy_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_rdata   = resp_rdata_q;
   assign bus.resp_illegal = resp_illegal_q;
   assign bus.csr_addr     = csr_addr_q;
   assign bus.csr_wdata    = csr_wdata_q;
   assign bus.csr_w_enable = csr_w_enable_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit. A behavioural CSR file answers reads
// combinationally and applies writes on the clock edge. Expected results are
// queued when a request is driven and compared when the response arrives.
module tb_csr_access_unit;
   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   csr_access_unit_if #(.XLEN(XLEN), .CSR_ADDR_W(AW)) bus ();

   csr_access_unit #(.XLEN(XLEN), .CSR_ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural CSR file with a preload port used by the tests
   logic [31:0] csr_mem [4096];
   logic        pre_en   = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [31:0] pre_data = '0;
   int          wr_cnt   = 0;
   logic [31:0] wr_data  = '0;
   logic [11:0] wr_addr  = '0;
   int          cyc      = 0;

   assign bus.csr_rdata = csr_mem[bus.csr_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pre_en) begin
         csr_mem[pre_addr] <= pre_data;
      end else if (bus.csr_w_enable) begin
         csr_mem[bus.csr_addr] <= bus.csr_wdata;
         wr_cnt  <= wr_cnt + 1;
         wr_data <= bus.csr_wdata;
         wr_addr <= bus.csr_addr;
      end
   end

   typedef struct {
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [31:0] rs1;
      logic [4:0]  zimm;
      logic [31:0] rdata;
      logic        ill;
      int          nwr;
      logic [31:0] wdata;
   } op_t;

   op_t sb[$];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      pre_en   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick;
      pre_en   = 1'b0;
   endtask

   // Drive one request, collect its response and count the write strobes it caused
   task automatic do_op(input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] zimm,
                        output logic [31:0] rdata, output logic ill,
                        output int lat, output int nwr, output int acc_cyc);
      int w0;
      int to;
      to = 0;
      while (!bus.req_ready && to < 20) begin
         tick;
         to++;
      end
      bus.req_valid    = 1'b1;
      bus.req_funct3   = f3;
      bus.req_addr     = addr;
      bus.req_rs1_data = rs1;
      bus.req_zimm     = zimm;
      w0 = wr_cnt;
      tick;
      acc_cyc = cyc;
      bus.req_valid = 1'b0;
      lat = 0;
      while (!bus.resp_valid && lat < 20) begin
         tick;
         lat++;
      end
      if (!bus.resp_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL resp_timeout: resp_valid got 0 want 1 after %0d cycles", lat);
      end
      rdata = bus.resp_rdata;
      ill   = bus.resp_illegal;
      bus.resp_ready = 1'b1;
      tick;
      bus.resp_ready = 1'b0;
      nwr = wr_cnt - w0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #23;
      n_checks++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready/busy/valid got %b%b%b want 100",
                  bus.req_ready, bus.busy, bus.resp_valid);
      end
      n_checks++;
      if (bus.resp_rdata !== 32'h0 || bus.resp_illegal !== 1'b0 || bus.csr_addr !== 12'h0 ||
          bus.csr_wdata !== 32'h0 || bus.csr_w_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_data: rdata=%h ill=%b addr=%h wdata=%h we=%b want all zero",
                  bus.resp_rdata, bus.resp_illegal, bus.csr_addr, bus.csr_wdata, bus.csr_w_enable);
      end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_rw_raw;
      op_t ops[2];
      op_t e;
      logic [31:0] rd;
      logic il;
      int lat, nwr, acc;
      preload(12'h305, 32'h0);
      ops[0] = '{3'b001, 12'h305, 32'h8000_0100, 5'd0, 32'h0,         1'b0, 1, 32'h8000_0100};
      ops[1] = '{3'b010, 12'h305, 32'h0,         5'd0, 32'h8000_0100, 1'b0, 0, 32'h0};
      for (int i = 0; i < 2; i++) begin
         sb.push_back(ops[i]);
         do_op(ops[i].f3, ops[i].addr, ops[i].rs1, ops[i].zimm, rd, il, lat, nwr, acc);
         e = sb.pop_front();
         n_checks++;
         if (rd !== e.rdata || il !== e.ill) begin
            n_fail++;
            $display("FAIL rw_resp op%0d: rdata=%h ill=%b want %h %b", i, rd, il, e.rdata, e.ill);
         end
         n_checks++;
         if (lat !== 2 || nwr !== e.nwr) begin
            n_fail++;
            $display("FAIL rw_timing op%0d: latency=%0d writes=%0d want 2 %0d", i, lat, nwr, e.nwr);
         end
         if (e.nwr == 1) begin
            n_checks++;
            if (wr_data !== e.wdata || wr_addr !== e.addr) begin
               n_fail++;
               $display("FAIL rw_wdata op%0d: wdata=%h addr=%h want %h %h",
                        i, wr_data, wr_addr, e.wdata, e.addr);
            end
         end
      end
   endtask

   task automatic test_set_clear;
      op_t ops[5];
      op_t e;
      logic [31:0] rd;
      logic il;
      int lat, nwr, acc;
      preload(12'h300, 32'h0000_00F0);
      preload(12'h341, 32'h0000_1234);
      preload(12'h342, 32'h0000_00FF);
      preload(12'h343, 32'h0000_AAAA);
      ops[0] = '{3'b010, 12'h300, 32'h0000_000F, 5'd0,  32'h0000_00F0, 1'b0, 1, 32'h0000_00FF};
      ops[1] = '{3'b011, 12'h341, 32'h0,         5'd0,  32'h0000_1234, 1'b0, 0, 32'h0};
      ops[2] = '{3'b111, 12'h342, 32'hFFFF_FFFF, 5'd3,  32'h0000_00FF, 1'b0, 1, 32'h0000_00FC};
      ops[3] = '{3'b110, 12'h342, 32'h0000_FFFF, 5'd0,  32'h0000_00FC, 1'b0, 0, 32'h0};
      ops[4] = '{3'b101, 12'h343, 32'h0,         5'd31, 32'h0000_AAAA, 1'b0, 1, 32'h0000_001F};
      for (int i = 0; i < 5; i++) begin
         sb.push_back(ops[i]);
         do_op(ops[i].f3, ops[i].addr, ops[i].rs1, ops[i].zimm, rd, il, lat, nwr, acc);
         e = sb.pop_front();
         n_checks++;
         if (rd !== e.rdata || il !== e.ill || nwr !== e.nwr) begin
            n_fail++;
            $display("FAIL setclr_resp op%0d: rdata=%h ill=%b writes=%0d want %h %b %0d",
                     i, rd, il, nwr, e.rdata, e.ill, e.nwr);
         end
         if (e.nwr == 1) begin
            n_checks++;
            if (wr_data !== e.wdata || wr_addr !== e.addr) begin
               n_fail++;
               $display("FAIL setclr_wdata op%0d: wdata=%h addr=%h want %h %h",
                        i, wr_data, wr_addr, e.wdata, e.addr);
            end
         end
      end
   endtask

   task automatic test_ro_illegal;
      op_t ops[4];
      op_t e;
      logic [31:0] rd;
      logic il;
      int lat, nwr, acc;
      preload(12'hC00, 32'h0000_ABCD);
      preload(12'h306, 32'h0000_005A);
      ops[0] = '{3'b010, 12'hC00, 32'h0,  5'd0, 32'h0000_ABCD, 1'b0, 0, 32'h0};
`ifdef CSR_ACCESS_RO_CHECK_EN
      ops[1] = '{3'b001, 12'hC00, 32'h55, 5'd0, 32'h0,         1'b1, 0, 32'h0};
`else
      ops[1] = '{3'b001, 12'hC00, 32'h55, 5'd0, 32'h0000_ABCD, 1'b0, 1, 32'h55};
`endif
      ops[2] = '{3'b100, 12'h306, 32'h5,  5'd0, 32'h0,         1'b1, 0, 32'h0};
      ops[3] = '{3'b000, 12'h306, 32'h5,  5'd0, 32'h0,         1'b1, 0, 32'h0};
      for (int i = 0; i < 4; i++) begin
         sb.push_back(ops[i]);
         do_op(ops[i].f3, ops[i].addr, ops[i].rs1, ops[i].zimm, rd, il, lat, nwr, acc);
         e = sb.pop_front();
         n_checks++;
         if (rd !== e.rdata || il !== e.ill || nwr !== e.nwr) begin
            n_fail++;
            $display("FAIL ro_resp op%0d: rdata=%h ill=%b writes=%0d want %h %b %0d",
                     i, rd, il, nwr, e.rdata, e.ill, e.nwr);
         end
         if (e.nwr == 1) begin
            n_checks++;
            if (wr_data !== e.wdata || wr_addr !== e.addr) begin
               n_fail++;
               $display("FAIL ro_wdata op%0d: wdata=%h addr=%h want %h %h",
                        i, wr_data, wr_addr, e.wdata, e.addr);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int w0;
      int to;
      int late_valid;
      preload(12'h350, 32'h66);
      preload(12'h351, 32'h10);
      w0 = wr_cnt;
      bus.req_valid    = 1'b1;
      bus.req_funct3   = 3'b001;
      bus.req_addr     = 12'h350;
      bus.req_rs1_data = 32'h77;
      bus.req_zimm     = 5'd0;
      tick;
      bus.req_valid = 1'b0;
      to = 0;
      while (!bus.resp_valid && to < 20) begin
         tick;
         to++;
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h66 || bus.resp_illegal !== 1'b0 ||
             bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold cyc%0d: valid=%b rdata=%h ill=%b ready=%b busy=%b want 1 66 0 0 1",
                     i, bus.resp_valid, bus.resp_rdata, bus.resp_illegal, bus.req_ready, bus.busy);
         end
         // A competing request while the response is stalled must be ignored
         bus.req_valid    = 1'b1;
         bus.req_addr     = 12'h351;
         bus.req_rs1_data = 32'h99;
         tick;
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      tick;
      bus.resp_ready = 1'b0;
      late_valid = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) late_valid++;
         tick;
      end
      n_checks++;
      if (late_valid != 0) begin
         n_fail++;
         $display("FAIL bp_ignored: spurious active cycles=%0d want 0", late_valid);
      end
      n_checks++;
      if (wr_cnt - w0 != 1 || csr_mem[12'h351] !== 32'h10 || csr_mem[12'h350] !== 32'h77) begin
         n_fail++;
         $display("FAIL bp_writes: writes=%0d csr351=%h csr350=%h want 1 10 77",
                  wr_cnt - w0, csr_mem[12'h351], csr_mem[12'h350]);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd;
      logic il;
      int lat, nwr, acc0, acc1;
      preload(12'h360, 32'h1);
      do_op(3'b001, 12'h360, 32'h2, 5'd0, rd, il, lat, nwr, acc0);
      do_op(3'b010, 12'h360, 32'h4, 5'd0, rd, il, lat, nwr, acc1);
      n_checks++;
      if (acc1 - acc0 != 4 || rd !== 32'h2) begin
         n_fail++;
         $display("FAIL b2b: interval=%0d rdata=%h want 4 00000002", acc1 - acc0, rd);
      end
   endtask

   task automatic test_reset_mid_write;
      int to;
      preload(12'h340, 32'h11);
      bus.req_valid    = 1'b1;
      bus.req_funct3   = 3'b001;
      bus.req_addr     = 12'h340;
      bus.req_rs1_data = 32'h22;
      bus.req_zimm     = 5'd0;
      tick;
      bus.req_valid = 1'b0;
      tick;
      n_checks++;
      if (bus.csr_w_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_we_before: csr_w_enable=%b want 1", bus.csr_w_enable);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.csr_w_enable !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0 ||
          bus.resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: we=%b ready=%b busy=%b valid=%b want 0 1 0 0",
                  bus.csr_w_enable, bus.req_ready, bus.busy, bus.resp_valid);
      end
      #2 rst_n = 1'b1;
      to = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (bus.resp_valid !== 1'b0) to++;
      end
      n_checks++;
      if (to != 0 || csr_mem[12'h340] !== 32'h11) begin
         n_fail++;
         $display("FAIL mid_after: resp cycles=%0d csr340=%h want 0 00000011", to, csr_mem[12'h340]);
      end
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_funct3   = 3'b000;
      bus.req_addr     = '0;
      bus.req_rs1_data = '0;
      bus.req_zimm     = '0;
      bus.resp_ready   = 1'b0;
      test_reset;
      test_rw_raw;
      test_set_clear;
      test_ro_illegal;
      test_backpressure;
      test_back_to_back;
      test_reset_mid_write;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
